serial_arbiter_n: RTL and testbench

N-master serial-bus arbiter: the parametrised successor of the two-master bus arbiter. It accepts level requests on each master's serial `tx` line, grants one master with a one-cycle strobe on its `rx` line, and shifts in that master's serial slave address. It then presents the address to the address decoder and tracks the slave handshake until release. New capabilities: N masters, selectable fixed/round-robin priority, one split slot with resume re-grant, and a slave-response timeout.

---
 rtl/bus_pkg.sv | 15 +
 rtl/arb_picker.sv | 40 ++++
 rtl/serial_arbiter_n.sv | 183 ++++++++++++++++++
 tb/tb_serial_arbiter_n.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared serial-bus types: arbiter state encoding and priority-mode constants,
// also used by the address decoder.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ADDR     = 2'd1,
    WAIT_SLV = 2'd2,
    BUSY     = 2'd3
  } arb_state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

endpackage

// File: rtl/arb_picker.sv
// Combinational one-hot request picker: searches upward from a base index,
// wrapping at N_MASTERS. Fixed-priority mode always searches from index 0.
module arb_picker
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int MODE      = ARB_FIXED
) (
  input  logic [N_MASTERS-1:0]         req,
  input  logic [$clog2(N_MASTERS)-1:0] base,
  output logic [N_MASTERS-1:0]         onehot,
  output logic [$clog2(N_MASTERS)-1:0] idx,
  output logic                         any
);

  localparam int IW = $clog2(N_MASTERS);

  logic [IW-1:0] eff_base;
  logic [IW:0]   pos;

  assign eff_base = (MODE == ARB_RR) ? base : '0;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      // One spare bit holds base+i before the wrap back into range.
      pos = {1'b0, eff_base} + (IW+1)'(i);
      if (pos >= (IW+1)'(N_MASTERS)) pos = pos - (IW+1)'(N_MASTERS);
      if (!any && req[pos[IW-1:0]]) begin
        any                 = 1'b1;
        onehot[pos[IW-1:0]] = 1'b1;
        idx                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/serial_arbiter_n.sv
// N-master serial-bus arbiter: grants a requesting master, shifts in its serial
// slave address, then tracks the slave handshake with one split slot and a timeout.
module serial_arbiter_n
  import bus_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 2,
  parameter int MODE      = ARB_FIXED,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_tx,
  output logic [N_MASTERS-1:0] m_rx,
  output logic [N_MASTERS-1:0] grant,
  output logic [ADDR_W-1:0]    addr,
  output logic                 addr_rdy,
  input  logic                 slv_ready,
  input  logic                 slv_responded,
  input  logic                 slv_split,
  input  logic                 slv_resume,
  output logic                 bus_busy,
  output logic                 timeout,
  output arb_state_t           state
);

  localparam int IW = $clog2(N_MASTERS);
  localparam int BW = $clog2(ADDR_W + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t cur_state, nxt_state;
  logic [N_MASTERS-1:0] nxt_grant, nxt_m_rx, split_mask, pick_onehot;
  logic [ADDR_W-1:0]    nxt_addr, shift, nxt_shift, shift_in, slot_addr, nxt_slot_addr;
  logic [IW-1:0]        own_idx, nxt_own, slot_idx, nxt_slot_idx;
  logic [IW-1:0]        last_grant, nxt_last, pick_base, pick_idx;
  logic [BW-1:0]        bit_cnt, nxt_bit_cnt;
  logic [TW-1:0]        tcnt, nxt_tcnt, tcnt_inc;
  logic nxt_addr_rdy, nxt_timeout, slot_valid, nxt_slot_valid;
  logic resume_pend, nxt_resume, pick_any, split_take;

  assign state     = cur_state;
  assign pick_base = (last_grant == IW'(N_MASTERS-1)) ? '0 : last_grant + IW'(1);
  assign shift_in  = (shift << 1) | ADDR_W'(m_tx[own_idx]);
  assign tcnt_inc  = tcnt + TW'(1);
  // A split while the slot is already occupied is treated as if it never came.
  assign split_take = slv_split && !slot_valid;

  always_comb begin
    split_mask = '0;
    if (slot_valid) split_mask[slot_idx] = 1'b1;
  end

  arb_picker #(.N_MASTERS(N_MASTERS), .MODE(MODE)) u_picker (
    .req    (~m_tx & ~split_mask),
    .base   (pick_base),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Slave handshake: slv_ready/slv_responded/slv_split are single-cycle levels
  // sampled only while a master owns the bus; priority responded > split > ready.
  always_comb begin
    nxt_state      = cur_state;
    nxt_grant      = grant;
    nxt_m_rx       = '1;
    nxt_addr       = addr;
    nxt_addr_rdy   = 1'b0;
    nxt_timeout    = 1'b0;
    nxt_own        = own_idx;
    nxt_shift      = shift;
    nxt_bit_cnt    = bit_cnt;
    nxt_tcnt       = tcnt;
    nxt_slot_valid = slot_valid;
    nxt_slot_idx   = slot_idx;
    nxt_slot_addr  = slot_addr;
    nxt_resume     = resume_pend;
    nxt_last       = last_grant;

    if (slv_resume && slot_valid && !slv_split) nxt_resume = 1'b1;

    unique case (cur_state)
      IDLE: begin
        if (resume_pend) begin
          nxt_grant           = '0;
          nxt_grant[slot_idx] = 1'b1;
          nxt_own             = slot_idx;
          nxt_addr            = slot_addr;
          nxt_addr_rdy        = 1'b1;
          nxt_tcnt            = '0;
          nxt_slot_valid      = 1'b0;
          nxt_resume          = 1'b0;
          nxt_state           = WAIT_SLV;
        end else if (pick_any) begin
          nxt_grant   = pick_onehot;
          nxt_m_rx    = ~pick_onehot;
          nxt_own     = pick_idx;
          nxt_last    = pick_idx;
          nxt_bit_cnt = '0;
          nxt_state   = ADDR;
        end
      end
      ADDR: begin
        // Count 0 is the strobe cycle; address bits arrive on counts 1..ADDR_W.
        if (bit_cnt == '0) begin
          nxt_bit_cnt = BW'(1);
        end else begin
          nxt_shift = shift_in;
          if (bit_cnt == BW'(ADDR_W)) begin
            nxt_addr     = shift_in;
            nxt_addr_rdy = 1'b1;
            nxt_tcnt     = '0;
            nxt_state    = WAIT_SLV;
          end else begin
            nxt_bit_cnt = bit_cnt + BW'(1);
          end
        end
      end
      WAIT_SLV, BUSY: begin
        if (slv_responded) begin
          nxt_grant = '0;
          nxt_state = IDLE;
        end else if (split_take) begin
          nxt_slot_valid = 1'b1;
          nxt_slot_idx   = own_idx;
          nxt_slot_addr  = addr;
          nxt_grant      = '0;
          nxt_state      = IDLE;
        end else if (cur_state == WAIT_SLV) begin
          if (slv_ready) begin
            nxt_state = BUSY;
          end else if (TIMEOUT != 0 && tcnt_inc == TW'(TIMEOUT)) begin
            nxt_timeout = 1'b1;
            nxt_grant   = '0;
            nxt_state   = IDLE;
          end else begin
            nxt_tcnt = tcnt_inc;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state   <= IDLE;
      grant       <= '0;
      m_rx        <= '1;
      addr        <= '0;
      addr_rdy    <= 1'b0;
      bus_busy    <= 1'b0;
      timeout     <= 1'b0;
      own_idx     <= '0;
      shift       <= '0;
      bit_cnt     <= '0;
      tcnt        <= '0;
      slot_valid  <= 1'b0;
      slot_idx    <= '0;
      slot_addr   <= '0;
      resume_pend <= 1'b0;
      last_grant  <= IW'(N_MASTERS-1);
    end else begin
      cur_state   <= nxt_state;
      grant       <= nxt_grant;
      m_rx        <= nxt_m_rx;
      addr        <= nxt_addr;
      addr_rdy    <= nxt_addr_rdy;
      bus_busy    <= (nxt_state != IDLE);
      timeout     <= nxt_timeout;
      own_idx     <= nxt_own;
      shift       <= nxt_shift;
      bit_cnt     <= nxt_bit_cnt;
      tcnt        <= nxt_tcnt;
      slot_valid  <= nxt_slot_valid;
      slot_idx    <= nxt_slot_idx;
      slot_addr   <= nxt_slot_addr;
      resume_pend <= nxt_resume;
      last_grant  <= nxt_last;
    end
  end

endmodule

// File: tb/tb_serial_arbiter_n.sv
// Directed bench for serial_arbiter_n: a fixed-priority and a round-robin
// instance share stimulus; expected values are hand-computed per scenario.
module tb_serial_arbiter_n;
  import bus_pkg::*;

  localparam int N  = 4;
  localparam int AW = 2;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] m_tx;
  logic slv_ready, slv_responded, slv_split, slv_resume;

  logic [N-1:0]  m_rx0, grant0, m_rx1, grant1;
  logic [AW-1:0] addr0, addr1;
  logic addr_rdy0, bus_busy0, timeout0, addr_rdy1, bus_busy1, timeout1;
  arb_state_t state0, state1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_arbiter_n #(.N_MASTERS(N), .ADDR_W(AW), .MODE(ARB_FIXED), .TIMEOUT(TO)) dut0 (
    .clk(clk), .rst(rst), .m_tx(m_tx), .m_rx(m_rx0), .grant(grant0), .addr(addr0),
    .addr_rdy(addr_rdy0), .slv_ready(slv_ready), .slv_responded(slv_responded),
    .slv_split(slv_split), .slv_resume(slv_resume), .bus_busy(bus_busy0),
    .timeout(timeout0), .state(state0)
  );

  serial_arbiter_n #(.N_MASTERS(N), .ADDR_W(AW), .MODE(ARB_RR), .TIMEOUT(TO)) dut1 (
    .clk(clk), .rst(rst), .m_tx(m_tx), .m_rx(m_rx1), .grant(grant1), .addr(addr1),
    .addr_rdy(addr_rdy1), .slv_ready(slv_ready), .slv_responded(slv_responded),
    .slv_split(slv_split), .slv_resume(slv_resume), .bus_busy(bus_busy1),
    .timeout(timeout1), .state(state1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_addr(input string tag);
    logic [AW-1:0] e;
    e = exp_q.pop_front();
    check(tag, addr0, e);
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Master m requests, checks the strobe, sends address a MSB first and
  // returns in the addr_rdy cycle (first WAIT_SLV cycle).
  task automatic fresh_grant(input int m, input logic [AW-1:0] a);
    logic [N-1:0] oh, rx;
    oh = N'(1) << m;
    rx = ~oh;
    m_tx[m] = 1'b0;
    step();
    check("strobe", m_rx0, rx);
    check("grant", grant0, oh);
    m_tx[m] = 1'b1;
    exp_q.push_back(a);
    step();
    check("strobe_end", m_rx0, 4'hf);
    m_tx[m] = a[1];
    step();
    m_tx[m] = a[0];
    step();
    check("addr_rdy", addr_rdy0, 1'b1);
    check_addr("addr");
    m_tx[m] = 1'b1;
  endtask

  task automatic release_bus();
    slv_responded = 1'b1;
    step();
    slv_responded = 1'b0;
    check("release_grant", grant0, 4'h0);
    check("release_busy", bus_busy0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    m_tx = '1;
    slv_ready = 1'b0;
    slv_responded = 1'b0;
    slv_split = 1'b0;
    slv_resume = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset values
    check("rst_grant", grant0, 4'h0);
    check("rst_m_rx", m_rx0, 4'hf);
    check("rst_addr", addr0, 2'b00);
    check("rst_addr_rdy", addr_rdy0, 1'b0);
    check("rst_busy", bus_busy0, 1'b0);
    check("rst_timeout", timeout0, 1'b0);
    check("rst_state", state0, IDLE);

    // Basic grant of master 2 with address 10, then ready and respond
    fresh_grant(2, 2'b10);
    check("addr_state", state0, WAIT_SLV);
    slv_ready = 1'b1;
    step();
    slv_ready = 1'b0;
    check("busy_state", state0, BUSY);
    check("addr_rdy_drop", addr_rdy0, 1'b0);
    check("busy_grant", grant0, 4'b0100);
    release_bus();

    // Priority: prime last_grant=1, then masters 1 and 3 request together
    fresh_grant(1, 2'b01);
    release_bus();
    m_tx[1] = 1'b0;
    m_tx[3] = 1'b0;
    step();
    check("fixed_grant", grant0, 4'b0010);
    check("fixed_strobe", m_rx0, 4'b1101);
    check("rr_grant", grant1, 4'b1000);
    check("rr_strobe", m_rx1, 4'b0111);
    m_tx[1] = 1'b1;
    exp_q.push_back(2'b11);
    step();
    m_tx[1] = 1'b1;
    step();
    m_tx[1] = 1'b1;
    step();
    check("fixed_addr_rdy", addr_rdy0, 1'b1);
    check_addr("fixed_addr");
    release_bus();
    step();
    check("fixed_second_grant", grant0, 4'b1000);
    check("fixed_second_strobe", m_rx0, 4'b0111);
    m_tx[3] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst2_grant", grant0, 4'h0);

    // Split: master 0 (addr 01) split in BUSY, master 1 served, then resume
    fresh_grant(0, 2'b01);
    slv_ready = 1'b1;
    step();
    slv_ready = 1'b0;
    m_tx[0] = 1'b0;
    m_tx[1] = 1'b0;
    slv_split = 1'b1;
    step();
    slv_split = 1'b0;
    check("split_grant", grant0, 4'h0);
    check("split_busy", bus_busy0, 1'b0);
    fresh_grant(1, 2'b11);
    release_bus();
    step();
    check("split_masked", grant0, 4'h0);
    m_tx[0] = 1'b1;
    slv_resume = 1'b1;
    step();
    slv_resume = 1'b0;
    check("resume_wait", grant0, 4'h0);
    exp_q.push_back(2'b01);
    step();
    check("resume_grant", grant0, 4'b0001);
    check("resume_addr_rdy", addr_rdy0, 1'b1);
    check_addr("resume_addr");
    check("resume_no_strobe", m_rx0, 4'hf);
    check("resume_state", state0, WAIT_SLV);
    release_bus();

    // Timeout: no slave answer, master 3 waits
    fresh_grant(2, 2'b11);
    m_tx[3] = 1'b0;
    for (int i = 0; i < TO - 1; i++) step();
    check("to_before_pulse", timeout0, 1'b0);
    check("to_before_grant", grant0, 4'b0100);
    step();
    check("to_pulse", timeout0, 1'b1);
    check("to_grant", grant0, 4'h0);
    check("to_state", state0, IDLE);
    step();
    check("to_pulse_end", timeout0, 1'b0);
    check("to_next_grant", grant0, 4'b1000);
    m_tx[3] = 1'b1;
    exp_q.push_back(2'b10);
    step();
    m_tx[3] = 1'b1;
    step();
    m_tx[3] = 1'b0;
    step();
    check("to_m3_addr_rdy", addr_rdy0, 1'b1);
    check_addr("to_m3_addr");
    m_tx[3] = 1'b1;
    slv_split = 1'b1;
    step();
    slv_split = 1'b0;
    check("to_m3_split", grant0, 4'h0);

    // Reset during ADDR with a split outstanding
    m_tx[0] = 1'b0;
    step();
    check("mid_grant", grant0, 4'b0001);
    m_tx[0] = 1'b1;
    step();
    check("mid_state", state0, ADDR);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_grant", grant0, 4'h0);
    check("mid_rst_m_rx", m_rx0, 4'hf);
    check("mid_rst_addr", addr0, 2'b00);
    check("mid_rst_addr_rdy", addr_rdy0, 1'b0);
    check("mid_rst_busy", bus_busy0, 1'b0);
    check("mid_rst_state", state0, IDLE);
    check("mid_rst_rr_grant", grant1, 4'h0);
    slv_resume = 1'b1;
    step();
    slv_resume = 1'b0;
    step();
    check("post_rst_resume_grant", grant0, 4'h0);
    check("post_rst_resume_rdy", addr_rdy0, 1'b0);

    // Responded and split together: release, slot stays empty
    fresh_grant(0, 2'b10);
    slv_ready = 1'b1;
    step();
    slv_ready = 1'b0;
    slv_responded = 1'b1;
    slv_split = 1'b1;
    step();
    slv_responded = 1'b0;
    slv_split = 1'b0;
    check("both_grant", grant0, 4'h0);
    check("both_state", state0, IDLE);
    fresh_grant(1, 2'b01);
    slv_ready = 1'b1;
    step();
    slv_ready = 1'b0;
    slv_split = 1'b1;
    step();
    slv_split = 1'b0;
    check("slot_empty_split", grant0, 4'h0);
    fresh_grant(2, 2'b11);
    slv_ready = 1'b1;
    step();
    slv_ready = 1'b0;
    slv_split = 1'b1;
    step();
    slv_split = 1'b0;
    check("full_split_grant", grant0, 4'b0100);
    check("full_split_state", state0, BUSY);
    release_bus();
    slv_resume = 1'b1;
    step();
    slv_resume = 1'b0;
    exp_q.push_back(2'b01);
    step();
    check("slot_owner_grant", grant0, 4'b0010);
    check_addr("slot_owner_addr");
    release_bus();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
